manual_drive_ctrl: RTL and testbench
====================================

# manual_drive_ctrl

Second-generation manual-driving controller for the car simulator. It debounces the raw board switches and runs the engine/gear state machine. Its outputs are:
- the 8-bit motion command byte consumed by the UART sender;
- a saturating mileage counter;
- blinking turn indicators.

All timing constants are parameters, so the same RTL serves the board (100 MHz) and fast simulation. It adds three things the first generation did not have: power on/off sequencing, a reverse gear and registered outputs.

## Interface
- CLK_HZ, 100_000_000, system clock frequency (documentation only; not used in RTL arithmetic)
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before a debounced input changes
- POWER_HOLD_CYCLES, 100_000_000, cycles power_on must be held to power up
- MILEAGE_TICK_CYCLES, 100_000_000, MOVING cycles per mileage increment
- MILEAGE_WIDTH, 16, mileage counter width
- BLINK_CYCLES, 50_000_000, half-period of turn-LED blink
- clk  in  1  system clock (P17)
- rst  in  1  synchronous, active-high reset
- power_on, power_off, throttle, clutch, brake, reverse, turn_left, turn_right, place_barrier, destroy_barrier  in  1 each  raw switches/buttons, all active-high, asynchronous to clk
- state  out  2  00 POWER_OFF, 01 NOT_STARTING, 10 STARTING, 11 MOVING
- cmd  out  8  {2'b10, destroy, place, right, left, backward, forward}
- mileage  out  MILEAGE_WIDTH  distance units travelled
- left_led, right_led, power_led  out  1 each

## Operation
**Input conditioning**
- Every raw input passes through a 2-flop synchroniser, then a per-input debouncer.
- The debounced value takes the synchronised value only after that value has differed from the current debounced value for DEBOUNCE_CYCLES consecutive cycles.
- Any bounce restarts that input's count.

**State machine.** All conditions use debounced signals. power_off has the highest priority from every powered state.
- POWER_OFF:
  - A hold counter counts while power_on = 1 and clears when power_on = 0.
  - When the count reaches POWER_HOLD_CYCLES, go to NOT_STARTING, clear mileage and clear the hold counter.
- NOT_STARTING, in priority order:
  - power_off → POWER_OFF.
  - throttle & ~clutch → POWER_OFF (stall).
  - throttle & clutch & ~brake → STARTING.
  - Otherwise stay.
- STARTING, in priority order:
  - power_off → POWER_OFF.
  - brake → NOT_STARTING.
  - throttle & ~clutch → MOVING.
  - Otherwise stay.
- MOVING, in priority order:
  - power_off → POWER_OFF.
  - brake → NOT_STARTING.
  - reverse differs from the latched gear & ~clutch → POWER_OFF (gear change without clutch).
  - ~throttle | clutch → STARTING.
  - Otherwise stay.
- Gear latch: captures reverse on every cycle the state is not MOVING, and on MOVING cycles with clutch = 1.

**Command byte**
- POWER_OFF and NOT_STARTING: cmd = 8'h80.
- STARTING: {2'b10, destroy, place, turn_right, turn_left, 2'b00}.
- MOVING: {2'b10, destroy, place, turn_right, turn_left, gear, ~gear}.

**Mileage**
- A tick counter runs only in MOVING and holds its value in other states.
- When it reaches MILEAGE_TICK_CYCLES−1 it wraps to 0 and mileage increments by 1.
- mileage saturates at all-ones.
- mileage is held through POWER_OFF and cleared only by rst or by power-up.

**LEDs**
- power_led = (state ≠ POWER_OFF).
- A blink phase toggles every BLINK_CYCLES cycles while powered and resets to 1 in POWER_OFF.
- left_led = turn_left & phase & powered; right_led follows the same rule with turn_right.
- When both turn signals are held, both LEDs blink in phase (hazard).

## Timing
- Reset: state = POWER_OFF, cmd = 8'h80, mileage = 0, all LEDs 0; all counters, debouncers and the gear latch = 0.
- Latency from a raw input edge to its debounced value: 2 + DEBOUNCE_CYCLES cycles.
- The state register updates on the edge after its debounced condition holds.
- cmd and the LEDs are registered: they reflect state and debounced inputs one cycle after state changes.
- rst asserted mid-operation overrides everything on the next edge, including a pending power-up count at POWER_HOLD_CYCLES−1.
- power_on released one cycle before the hold count completes: no power-up, and the hold counter returns to 0.
- A reverse toggle together with clutch = 1 in MOVING: the state stays MOVING (or goes to STARTING via the clutch rule) and the gear updates.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES = 4, POWER_HOLD_CYCLES = 10, MILEAGE_TICK_CYCLES = 5, BLINK_CYCLES = 3, MILEAGE_WIDTH = 4.
- Reset/power-up:
  - Hold power_on 9 debounced cycles, then release → state stays 00.
  - Hold power_on 10 debounced cycles → state = 01, power_led = 1, cmd = 8'h80.
- Normal drive:
  - clutch + throttle → state 10.
  - Drop clutch → state 11; with turn_left = 1 and gear forward, cmd = 8'b10000101.
- Mileage saturation: stay MOVING for 100 cycles → mileage reaches 4'hF and holds; brake → state 01, mileage remains F.
- Stall and bad shift:
  - throttle without clutch in 01 → state 00.
  - In 11, toggle reverse with clutch = 0 → state 00.
  - In 11, toggle reverse with clutch = 1 → state 10; then release clutch → state 11 with cmd[1:0] = 2'b10.
- Debounce: a power_off glitch shorter than 4 cycles → no state change; a 4-cycle pulse → state 00 from any powered state, even with brake asserted simultaneously.
- Blink/hazard: turn_left = turn_right = 1 while powered → both LEDs toggle every 3 cycles in phase; in POWER_OFF both LEDs stay 0.

Source files
------------

// File: rtl/manual_drive_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : manual_drive_ctrl
// Brief   : Manual-driving controller for the car simulator. Synchronises
//           and debounces the raw switches, sequences power and gears,
//           produces the UART motion command byte, a saturating mileage
//           counter and blinking turn indicators.
// Revision: 1.0 - initial release
// ============================================================================
module manual_drive_ctrl #(
    parameter int CLK_HZ              = 100_000_000,
    parameter int DEBOUNCE_CYCLES     = 1_000_000,
    parameter int POWER_HOLD_CYCLES   = 100_000_000,
    parameter int MILEAGE_TICK_CYCLES = 100_000_000,
    parameter int MILEAGE_WIDTH       = 16,
    parameter int BLINK_CYCLES        = 50_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     power_on,
    input  logic                     power_off,
    input  logic                     throttle,
    input  logic                     clutch,
    input  logic                     brake,
    input  logic                     reverse,
    input  logic                     turn_left,
    input  logic                     turn_right,
    input  logic                     place_barrier,
    input  logic                     destroy_barrier,
    output logic [1:0]               state,
    output logic [7:0]               cmd,
    output logic [MILEAGE_WIDTH-1:0] mileage,
    output logic                     left_led,
    output logic                     right_led,
    output logic                     power_led
);

    localparam int NUM_IN  = 10;
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W  = $clog2(POWER_HOLD_CYCLES + 1);
    localparam int TICK_W  = $clog2(MILEAGE_TICK_CYCLES + 1);
    localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);

    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(POWER_HOLD_CYCLES - 1);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(MILEAGE_TICK_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    // All timing constants must describe at least one clock cycle.
    if (CLK_HZ < 1 || DEBOUNCE_CYCLES < 1 || POWER_HOLD_CYCLES < 1 ||
        MILEAGE_TICK_CYCLES < 1 || BLINK_CYCLES < 1 || MILEAGE_WIDTH < 1) begin : g_param_check
        $error("manual_drive_ctrl: timing parameters must all be >= 1");
    end

    typedef enum logic [1:0] {
        POWER_OFF    = 2'b00,
        NOT_STARTING = 2'b01,
        STARTING     = 2'b10,
        MOVING       = 2'b11
    } state_t;

    logic [NUM_IN-1:0] raw_in;
    logic [NUM_IN-1:0] sync1;
    logic [NUM_IN-1:0] sync2;
    logic [NUM_IN-1:0] deb;
    logic [DB_W-1:0]   db_cnt [NUM_IN];

    state_t             cur_state;
    state_t             state_next;
    logic               power_up;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [TICK_W-1:0]  tick_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               phase;
    logic               gear;
    logic               powered;

    assign raw_in = {destroy_barrier, place_barrier, turn_right, turn_left, reverse,
                     brake, clutch, throttle, power_off, power_on};

    logic pon_d, poff_d, thr_d, clu_d, brk_d, rev_d, tl_d, tr_d, plc_d, dst_d;
    assign {dst_d, plc_d, tr_d, tl_d, rev_d, brk_d, clu_d, thr_d, poff_d, pon_d} = deb;

    assign state   = cur_state;
    assign powered = (cur_state != POWER_OFF);

    // Two-flop synchroniser followed by a run-length debouncer per input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int i = 0; i < NUM_IN; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
            for (int i = 0; i < NUM_IN; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) cur_state <= POWER_OFF;
        else     cur_state <= state_next;
    end

    // Next-state rules; power_off outranks everything once powered.
    always_comb begin
        state_next = cur_state;
        power_up   = 1'b0;
        case (cur_state)
            POWER_OFF: begin
                if (pon_d && hold_cnt == HOLD_LAST) begin
                    state_next = NOT_STARTING;
                    power_up   = 1'b1;
                end
            end
            NOT_STARTING: begin
                if (poff_d)                        state_next = POWER_OFF;
                else if (thr_d && !clu_d)          state_next = POWER_OFF;
                else if (thr_d && clu_d && !brk_d) state_next = STARTING;
            end
            STARTING: begin
                if (poff_d)               state_next = POWER_OFF;
                else if (brk_d)           state_next = NOT_STARTING;
                else if (thr_d && !clu_d) state_next = MOVING;
            end
            MOVING: begin
                if (poff_d)                     state_next = POWER_OFF;
                else if (brk_d)                 state_next = NOT_STARTING;
                else if (rev_d != gear && !clu_d) state_next = POWER_OFF;
                else if (!thr_d || clu_d)       state_next = STARTING;
            end
            default: state_next = POWER_OFF;
        endcase
    end

    // Power-on hold counter: counts consecutive power_on cycles while off.
    always_ff @(posedge clk) begin
        if (rst || cur_state != POWER_OFF || !pon_d || power_up) hold_cnt <= '0;
        else                                                    hold_cnt <= hold_cnt + 1'b1;
    end

    // Gear latch follows reverse except while moving with the clutch released.
    always_ff @(posedge clk) begin
        if (rst)                                  gear <= 1'b0;
        else if (cur_state != MOVING || clu_d)    gear <= rev_d;
    end

    // Mileage: tick counter advances only while moving; counter saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            mileage  <= '0;
        end else begin
            if (power_up) mileage <= '0;
            if (cur_state == MOVING) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_cnt <= '0;
                    if (mileage != '1) mileage <= mileage + 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end
        end
    end

    // Blink phase generator; parked at phase 1 while powered off.
    always_ff @(posedge clk) begin
        if (rst || !powered) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Registered command byte and LEDs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd       <= 8'h80;
            left_led  <= 1'b0;
            right_led <= 1'b0;
            power_led <= 1'b0;
        end else begin
            case (cur_state)
                STARTING: cmd <= {2'b10, dst_d, plc_d, tr_d, tl_d, 2'b00};
                MOVING:   cmd <= {2'b10, dst_d, plc_d, tr_d, tl_d, gear, ~gear};
                default:  cmd <= 8'h80;
            endcase
            left_led  <= tl_d & phase & powered;
            right_led <= tr_d & phase & powered;
            power_led <= powered;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_manual_drive_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_manual_drive_ctrl
// Brief   : Self-checking bench for manual_drive_ctrl: directed vector table,
//           hand-written blink/reset sequences and randomized stimulus
//           against a behavioural reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_manual_drive_ctrl;

    localparam int D = 4;
    localparam int P = 10;
    localparam int T = 5;
    localparam int B = 3;
    localparam int W = 4;

    localparam logic [9:0] PON  = 10'h001;
    localparam logic [9:0] POFF = 10'h002;
    localparam logic [9:0] THR  = 10'h004;
    localparam logic [9:0] CLU  = 10'h008;
    localparam logic [9:0] BRK  = 10'h010;
    localparam logic [9:0] REV  = 10'h020;
    localparam logic [9:0] TL   = 10'h040;
    localparam logic [9:0] TR   = 10'h080;
    localparam logic [9:0] PLC  = 10'h100;
    localparam logic [9:0] DST  = 10'h200;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [9:0]   raw = '0;
    logic [1:0]   state;
    logic [7:0]   cmd;
    logic [W-1:0] mileage;
    logic         left_led, right_led, power_led;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    manual_drive_ctrl #(
        .CLK_HZ(100), .DEBOUNCE_CYCLES(D), .POWER_HOLD_CYCLES(P),
        .MILEAGE_TICK_CYCLES(T), .MILEAGE_WIDTH(W), .BLINK_CYCLES(B)
    ) dut (
        .clk(clk), .rst(rst),
        .power_on(raw[0]), .power_off(raw[1]), .throttle(raw[2]), .clutch(raw[3]),
        .brake(raw[4]), .reverse(raw[5]), .turn_left(raw[6]), .turn_right(raw[7]),
        .place_barrier(raw[8]), .destroy_barrier(raw[9]),
        .state(state), .cmd(cmd), .mileage(mileage),
        .left_led(left_led), .right_led(right_led), .power_led(power_led)
    );

    // ---------------- reference model ----------------
    int           m_state, m_hold, m_total, m_base, m_prun;
    logic [7:0]   m_cmd;
    logic [W-1:0] m_mil;
    logic         m_l, m_r, m_p, m_gear, m_phase;
    logic [9:0]   m_deb;
    logic [9:0]   hist[$];

    task automatic model_step(input logic [9:0] r, input logic rs);
        logic [9:0] d, nd;
        int         ns, v;
        bit         up, powered, all_diff;
        if (rs) begin
            m_state = 0; m_cmd = 8'h80; m_mil = '0; m_l = 0; m_r = 0; m_p = 0;
            m_deb = '0; m_gear = 0; m_hold = 0; m_total = 0; m_base = 0;
            m_prun = 0; m_phase = 1;
            hist.delete();
            for (int j = 0; j <= D; j++) hist.push_back(10'h000);
            return;
        end
        d  = m_deb;
        nd = d;
        // A debounced bit flips once its last D synchronised samples all disagree.
        for (int i = 0; i < 10; i++) begin
            all_diff = 1;
            for (int j = 0; j < D; j++)
                if (hist[hist.size() - 2 - j][i] == d[i]) all_diff = 0;
            if (all_diff) nd[i] = ~d[i];
        end
        ns = m_state; up = 0;
        case (m_state)
            0: if (d[0] && m_hold + 1 == P) begin ns = 1; up = 1; end
            1: if (d[1]) ns = 0; else if (d[2] && !d[3]) ns = 0;
               else if (d[2] && d[3] && !d[4]) ns = 2;
            2: if (d[1]) ns = 0; else if (d[4]) ns = 1; else if (d[2] && !d[3]) ns = 3;
            default: if (d[1]) ns = 0; else if (d[4]) ns = 1;
               else if (d[5] != m_gear && !d[3]) ns = 0;
               else if (!d[2] || d[3]) ns = 2;
        endcase
        if (m_state == 0 && d[0] && !up) m_hold++; else m_hold = 0;
        powered = (m_state != 0);
        if (m_state == 2)      m_cmd = {2'b10, d[9], d[8], d[7], d[6], 2'b00};
        else if (m_state == 3) m_cmd = {2'b10, d[9], d[8], d[7], d[6], m_gear, ~m_gear};
        else                   m_cmd = 8'h80;
        m_l = d[6] & m_phase & powered;
        m_r = d[7] & m_phase & powered;
        m_p = powered;
        if (m_state == 3) m_total++;
        if (up) m_base = m_total;
        v = m_total / T - m_base / T;
        if (v > (1 << W) - 1) v = (1 << W) - 1;
        m_mil = W'(v);
        if (powered) begin
            m_prun++;
            m_phase = ((m_prun / B) % 2) == 0;
        end else begin
            m_prun = 0; m_phase = 1;
        end
        if (m_state != 3 || d[3]) m_gear = d[5];
        m_state = ns;
        m_deb   = nd;
        hist.push_back(r);
        void'(hist.pop_front());
    endtask

    task automatic check_model();
        logic [16:0] act, exp;
        act = {state, cmd, mileage, left_led, right_led, power_led};
        exp = {m_state[1:0], m_cmd, m_mil, m_l, m_r, m_p};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL model t=%0t: got st=%b cmd=%h mil=%h leds=%b%b%b, want st=%b cmd=%h mil=%h leds=%b%b%b",
                     $time, state, cmd, mileage, left_led, right_led, power_led,
                     m_state[1:0], m_cmd, m_mil, m_l, m_r, m_p);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step(raw, rst);
        #1;
        check_model();
    endtask

    task automatic expect_bits(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [9:0]   in;
        int           cycles;
        logic [1:0]   st;
        logic [7:0]   cmd;
        bit           chk_mil;
        logic [W-1:0] mil;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    logic [9:0] rnd;
    logic       prev;
    int         last_chg, toggles;

    initial begin
        tbl[0]  = '{10'h000,               3,   2'b00, 8'h80, 1'b1, 4'h0};
        tbl[1]  = '{PON,                   9,   2'b00, 8'h80, 1'b0, 4'h0};
        tbl[2]  = '{10'h000,               12,  2'b00, 8'h80, 1'b0, 4'h0};
        tbl[3]  = '{PON,                   20,  2'b01, 8'h80, 1'b1, 4'h0};
        tbl[4]  = '{CLU,                   12,  2'b01, 8'h80, 1'b0, 4'h0};
        tbl[5]  = '{CLU|THR|TL,            12,  2'b10, 8'h84, 1'b0, 4'h0};
        tbl[6]  = '{THR|TL,                12,  2'b11, 8'h85, 1'b0, 4'h0};
        tbl[7]  = '{THR|TL,                100, 2'b11, 8'h85, 1'b1, 4'hF};
        tbl[8]  = '{BRK|CLU|THR|TL,        12,  2'b01, 8'h80, 1'b1, 4'hF};
        tbl[9]  = '{THR|TL,                12,  2'b00, 8'h80, 1'b1, 4'hF};
        tbl[10] = '{10'h000,               12,  2'b00, 8'h80, 1'b1, 4'hF};
        tbl[11] = '{PON,                   20,  2'b01, 8'h80, 1'b1, 4'h0};
        tbl[12] = '{CLU,                   12,  2'b01, 8'h80, 1'b0, 4'h0};
        tbl[13] = '{CLU|THR,               12,  2'b10, 8'h80, 1'b0, 4'h0};
        tbl[14] = '{THR,                   12,  2'b11, 8'h81, 1'b0, 4'h0};
        tbl[15] = '{THR|REV,               12,  2'b00, 8'h80, 1'b0, 4'h0};
        tbl[16] = '{10'h000,               12,  2'b00, 8'h80, 1'b0, 4'h0};
        tbl[17] = '{PON,                   20,  2'b01, 8'h80, 1'b0, 4'h0};
        tbl[18] = '{CLU,                   12,  2'b01, 8'h80, 1'b0, 4'h0};
        tbl[19] = '{CLU|THR,               12,  2'b10, 8'h80, 1'b0, 4'h0};
        tbl[20] = '{THR|PLC|DST|TR,        12,  2'b11, 8'hB9, 1'b0, 4'h0};
        tbl[21] = '{CLU|THR|REV,           12,  2'b10, 8'h80, 1'b0, 4'h0};
        tbl[22] = '{THR|REV,               12,  2'b11, 8'h82, 1'b0, 4'h0};
        tbl[23] = '{THR|REV|POFF,          3,   2'b11, 8'h82, 1'b0, 4'h0};
        tbl[24] = '{THR|REV,               12,  2'b11, 8'h82, 1'b0, 4'h0};
        tbl[25] = '{THR|REV|POFF|BRK,      4,   2'b11, 8'h82, 1'b0, 4'h0};
        tbl[26] = '{THR|REV,               12,  2'b00, 8'h80, 1'b0, 4'h0};

        // Reset state.
        rst = 1'b1;
        repeat (3) step();
        expect_bits("reset_outputs", {1'b0, state, cmd, mileage, left_led, right_led, power_led},
                    {1'b0, 2'b00, 8'h80, 4'h0, 3'b000});
        rst = 1'b0;

        for (int k = 0; k < NV; k++) begin
            raw = tbl[k].in;
            repeat (tbl[k].cycles) step();
            expect_bits($sformatf("vec%0d_state", k), {14'h0, state}, {14'h0, tbl[k].st});
            expect_bits($sformatf("vec%0d_cmd", k), {8'h0, cmd}, {8'h0, tbl[k].cmd});
            if (tbl[k].chk_mil)
                expect_bits($sformatf("vec%0d_mileage", k), {12'h0, mileage}, {12'h0, tbl[k].mil});
        end

        // Hazard blink: both LEDs in phase, toggling every B cycles.
        raw = PON;     repeat (20) step();
        expect_bits("hazard_powered", {14'h0, state}, 16'h0001);
        raw = TL | TR; repeat (12) step();
        prev = left_led; last_chg = -1; toggles = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            expect_bits("hazard_in_phase", {15'h0, left_led}, {15'h0, right_led});
            if (left_led !== prev) begin
                if (last_chg >= 0)
                    expect_bits("hazard_interval", 16'(c - last_chg), 16'(B));
                last_chg = c; toggles++; prev = left_led;
            end
        end
        expect_bits("hazard_toggles", 16'(toggles), 16'd10);

        // Power off with turns held: LEDs dark.
        raw = POFF | TL | TR; repeat (8) step();
        for (int c = 0; c < 10; c++) begin
            step();
            expect_bits("off_leds_dark", {13'h0, left_led, right_led, power_led}, 16'h0000);
        end
        raw = TL | TR; repeat (8) step();

        // rst overrides a power-up that is due on the same edge.
        raw = PON;
        repeat (15) step();
        expect_bits("pre_powerup_state", {14'h0, state}, 16'h0000);
        rst = 1'b1; step(); rst = 1'b0;
        expect_bits("rst_override_state", {14'h0, state}, 16'h0000);
        repeat (5) step();
        expect_bits("requalify_state", {14'h0, state}, 16'h0000);
        repeat (11) step();
        expect_bits("powerup_after_rst", {14'h0, state}, 16'h0001);

        // Randomized stimulus against the reference model.
        rst = 1'b1; step(); rst = 1'b0;
        for (int s = 0; s < 160; s++) begin
            rnd    = 10'($urandom);
            rnd[1] = ($urandom_range(0, 9) == 0);
            rnd[4] = ($urandom_range(0, 4) == 0);
            raw    = rnd;
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1; step(); rst = 1'b0;
            end
            repeat ($urandom_range(1, 20)) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
